// File: rtl/packet_mux_pkg.sv
// Shared types and defaults for the packet mux output path and its sanitizer.
package packet_mux_pkg;

   localparam int DATA_W        = 64;
   localparam int EMPTY_W       = 3;
   localparam int MAX_PKT_BEATS = 256;
   localparam int STAT_CNT_W    = 32;

   typedef enum logic [1:0] {
      SAN_IDLE,
      SAN_IN_PKT,
      SAN_DISCARD
   } san_state_t;

endpackage

// File: rtl/pkt_stat_counter.sv
// Saturating statistics counter with synchronous clear that wins over increment.
module pkt_stat_counter #(
   parameter int CNT_W = 32,
   parameter int INC_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc_en,
   input  logic [INC_W-1:0] inc_amt,
   output logic [CNT_W-1:0] cnt
);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [INC_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + (CNT_W+1)'(b);
      return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (inc_en) begin
         cnt <= sat_add(cnt, inc_amt);
      end
   end

endmodule

// File: rtl/pkt_sanitizer.sv
// Framing sanitizer: repairs/drops malformed sop/eop framing, caps packet length,
// keeps saturating traffic statistics. One registered stage, full throughput.
module pkt_sanitizer #(
   parameter int DATA_W    = packet_mux_pkg::DATA_W,
   parameter int EMP_W     = packet_mux_pkg::EMPTY_W,
   parameter int MAX_BEATS = packet_mux_pkg::MAX_PKT_BEATS,
   parameter int CNT_W     = packet_mux_pkg::STAT_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_sop,
   input  logic              s_eop,
   input  logic [EMP_W-1:0]  s_empty,
   input  logic              s_error,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_sop,
   output logic              m_eop,
   output logic [EMP_W-1:0]  m_empty,
   output logic              m_error,
   input  logic              m_ready,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  stat_pkts,
   output logic [CNT_W-1:0]  stat_err_pkts,
   output logic [CNT_W-1:0]  stat_bytes,
   output logic [CNT_W-1:0]  stat_drop_beats
);
   import packet_mux_pkg::*;

   localparam int BC_W   = $clog2(MAX_BEATS + 1);
   localparam int BYTES  = DATA_W / 8;
   localparam int BYTE_W = $clog2(BYTES + 1);

   san_state_t        state;
   logic [BC_W-1:0]   beat_cnt;
   san_state_t        state_nx;
   logic [BC_W-1:0]   beat_cnt_nx;
   logic              accept;
   logic              fwd_p0;
   logic              sop_p0;
   logic              eop_p0;
   logic [EMP_W-1:0]  empty_p0;
   logic              error_p0;
   logic [BYTE_W-1:0] bytes_p0;

   assign s_ready = !m_valid || m_ready;
   assign accept  = s_valid && s_ready;

   // Stage p0: classify the incoming beat and build its sanitized framing
   always_comb begin
      fwd_p0      = 1'b0;
      sop_p0      = s_sop;
      eop_p0      = s_eop;
      empty_p0    = s_empty;
      error_p0    = s_error;
      state_nx    = state;
      beat_cnt_nx = beat_cnt;
      unique case (state)
         SAN_IN_PKT: begin
            fwd_p0 = 1'b1;
            if (s_sop) begin
               // A new sop implies the previous eop was lost: close the packet here.
               sop_p0      = 1'b0;
               eop_p0      = 1'b1;
               error_p0    = 1'b1;
               empty_p0    = '0;
               state_nx    = s_eop ? SAN_IDLE : SAN_DISCARD;
               beat_cnt_nx = '0;
            end else if (s_eop) begin
               state_nx    = SAN_IDLE;
               beat_cnt_nx = '0;
            end else if (beat_cnt == BC_W'(MAX_BEATS - 1)) begin
               eop_p0      = 1'b1;
               error_p0    = 1'b1;
               empty_p0    = '0;
               state_nx    = SAN_DISCARD;
               beat_cnt_nx = '0;
            end else begin
               beat_cnt_nx = beat_cnt + 1'b1;
            end
         end
         default: begin
            if (s_sop) begin
               fwd_p0      = 1'b1;
               state_nx    = s_eop ? SAN_IDLE : SAN_IN_PKT;
               beat_cnt_nx = s_eop ? '0 : BC_W'(1);
            end else if (state == SAN_DISCARD && s_eop) begin
               state_nx = SAN_IDLE;
            end
         end
      endcase
      if (!eop_p0) begin
         empty_p0 = '0;
      end
   end

   assign bytes_p0 = BYTE_W'(BYTES) - (eop_p0 ? BYTE_W'(empty_p0) : '0);

   // Stage p1: output register and FSM state, advanced only on accepted beats
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= SAN_IDLE;
         beat_cnt <= '0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_sop    <= 1'b0;
         m_eop    <= 1'b0;
         m_empty  <= '0;
         m_error  <= 1'b0;
      end else begin
         if (accept) begin
            state    <= state_nx;
            beat_cnt <= beat_cnt_nx;
         end
         if (accept && fwd_p0) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_sop   <= sop_p0;
            m_eop   <= eop_p0;
            m_empty <= empty_p0;
            m_error <= error_p0;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   pkt_stat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cnt_pkts (
      .clk(clk), .rst_n(rst_n), .clr(clr_stats),
      .inc_en(accept && fwd_p0 && eop_p0), .inc_amt(1'b1), .cnt(stat_pkts)
   );

   pkt_stat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cnt_err_pkts (
      .clk(clk), .rst_n(rst_n), .clr(clr_stats),
      .inc_en(accept && fwd_p0 && eop_p0 && error_p0), .inc_amt(1'b1), .cnt(stat_err_pkts)
   );

   pkt_stat_counter #(.CNT_W(CNT_W), .INC_W(BYTE_W)) u_cnt_bytes (
      .clk(clk), .rst_n(rst_n), .clr(clr_stats),
      .inc_en(accept && fwd_p0), .inc_amt(bytes_p0), .cnt(stat_bytes)
   );

   pkt_stat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cnt_drop (
      .clk(clk), .rst_n(rst_n), .clr(clr_stats),
      .inc_en(accept && !fwd_p0), .inc_amt(1'b1), .cnt(stat_drop_beats)
   );

endmodule
